bus_slave: RTL and testbench

// - Avalon-MM slave (responder) that converts bus transfers into the single-op device handshake (addr/start/write/ready) used inside the core.
// - Sits between the interconnect and a 32-bit word device (register file, memory wrapper); converts pipelined waitrequest semantics into start/ready pulses.
// - Optionally emulates byte writes for word-only devices via read-modify-write.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_slave_if.sv | 35 +++
 rtl/bus_slave.sv | 162 ++++++++++++++++
 tb/tb_bus_slave.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state enum, word type and byte-lane merge helper for bus_slave
package bus_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RMW_MERGE,
    DONE
  } bus_slave_state_t;

  // Per-lane select: enabled lanes take the new word, others keep the old word
  function automatic word_t be_merge(input word_t old_word, input word_t new_word,
                                     input logic [3:0] be);
    word_t merged;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = be[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/bus_slave_if.sv
// rtl/bus_slave_if.sv - Avalon-MM side and device side signals of bus_slave
interface bus_slave_if;
  import bus_pkg::*;

  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  word_t       avl_writedata;
  logic [3:0]  avl_byteenable;
  word_t       avl_readdata;
  logic        avl_waitrequest;

  logic [29:0] dev_addr;
  logic        dev_start;
  logic        dev_write;
  word_t       dev_data_wr;
  logic [3:0]  dev_be;
  logic        dev_ready;
  word_t       dev_data_rd;

  modport slave (
    input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    input  dev_ready, dev_data_rd,
    output avl_readdata, avl_waitrequest,
    output dev_addr, dev_start, dev_write, dev_data_wr, dev_be
  );

  modport master (
    output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
    output dev_ready, dev_data_rd,
    input  avl_readdata, avl_waitrequest,
    input  dev_addr, dev_start, dev_write, dev_data_wr, dev_be
  );

endinterface

// File: rtl/bus_slave.sv
// rtl/bus_slave.sv - Avalon-MM slave to start/ready device bridge; BUS_SLAVE_RMW_EN enables read-modify-write byte writes
module bus_slave
  import bus_pkg::*;
#(
  parameter int    TIMEOUT_CYCLES = 256,
  parameter word_t ABORT_DATA     = 32'hFFFF_FFFF
) (
  input logic        clk,
  input logic        rst_n,
  bus_slave_if.slave bus
);

  bus_slave_state_t state, next_state;

  logic [29:0] addr_q;
  word_t       data_wr_q;
  logic [3:0]  be_q;
  logic        write_q;
  word_t       readdata_q;
  logic        rmw_read_q;
  logic        timeout_hit;
  logic        dev_start;
  logic        waitrequest;

  // Byte offset is meaningless to a word device
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.avl_address[1:0];

`ifdef BUS_SLAVE_RMW_EN
  logic [3:0] lane_be_q;
  logic       be_partial;
  assign be_partial = (bus.avl_byteenable != 4'h0) && (bus.avl_byteenable != 4'hF);
`endif

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] to_cnt;

      // Count consecutive WAIT cycles without a device response
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          to_cnt <= '0;
        end else if (state == WAIT && !bus.dev_ready) begin
          to_cnt <= to_cnt + CW'(1);
        end else begin
          to_cnt <= '0;
        end
      end

      assign timeout_hit = (state == WAIT) && !bus.dev_ready &&
                           (to_cnt == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus start pulse and stall; stall is dropped only in DONE
  always_comb begin
    next_state  = state;
    dev_start   = 1'b0;
    waitrequest = 1'b1;
    case (state)
      IDLE: begin
        if (bus.avl_write) begin
          next_state = (bus.avl_byteenable == 4'h0) ? DONE : START;
        end else if (bus.avl_read) begin
          next_state = START;
        end
      end
      START: begin
        dev_start  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        if (bus.dev_ready) begin
          next_state = rmw_read_q ? RMW_MERGE : DONE;
        end else if (timeout_hit) begin
          next_state = DONE;
        end
      end
      RMW_MERGE: next_state = START;
      DONE: begin
        waitrequest = 1'b0;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the request, track the op phase and capture device or abort data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      data_wr_q  <= '0;
      be_q       <= '0;
      write_q    <= 1'b0;
      readdata_q <= '0;
      rmw_read_q <= 1'b0;
`ifdef BUS_SLAVE_RMW_EN
      lane_be_q  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.avl_write) begin
            addr_q    <= bus.avl_address[31:2];
            data_wr_q <= bus.avl_writedata;
`ifdef BUS_SLAVE_RMW_EN
            lane_be_q  <= bus.avl_byteenable;
            be_q       <= 4'hF;
            rmw_read_q <= be_partial;
            write_q    <= (bus.avl_byteenable == 4'hF);
`else
            be_q       <= bus.avl_byteenable;
            write_q    <= (bus.avl_byteenable != 4'h0);
`endif
          end else if (bus.avl_read) begin
            addr_q     <= bus.avl_address[31:2];
            be_q       <= 4'hF;
            write_q    <= 1'b0;
            rmw_read_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.dev_ready) begin
            readdata_q <= bus.dev_data_rd;
          end else if (timeout_hit) begin
            readdata_q <= ABORT_DATA;
          end
        end
`ifdef BUS_SLAVE_RMW_EN
        RMW_MERGE: begin
          data_wr_q  <= be_merge(readdata_q, data_wr_q, lane_be_q);
          write_q    <= 1'b1;
          rmw_read_q <= 1'b0;
        end
`endif
        DONE: write_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.avl_readdata    = readdata_q;
  assign bus.avl_waitrequest = waitrequest;
  assign bus.dev_addr        = addr_q;
  assign bus.dev_start       = dev_start;
  assign bus.dev_write       = write_q;
  assign bus.dev_data_wr     = data_wr_q;
  assign bus.dev_be          = be_q;

endmodule

// File: tb/tb_bus_slave.sv
// tb/tb_bus_slave.sv - scoreboard bench for bus_slave with random transfers and a device model
module tb_bus_slave;
  import bus_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bus_slave_if bus ();

  bus_slave #(.TIMEOUT_CYCLES(TO), .ABORT_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    int          req_cyc;
    int          cycles;
    int          starts;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          lat;
  } op_t;

  exp_t sb_q[$];
  op_t  op_q[$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] dev_mem [logic [29:0]];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int mon_starts = 0;
  exp_t mon_e;
  op_t  dev_op;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic logic [31:0] dev_rd(input logic [29:0] w);
    return dev_mem.exists(w) ? dev_mem[w] : 32'h0;
  endfunction

  task automatic preload(input logic [29:0] w, input logic [31:0] v);
    ref_mem[w] = v;
    dev_mem[w] = v;
  endtask

  // Device model: checks each op against the expected op list, answers after its latency
  initial begin
    bus.dev_ready = 1'b0;
    bus.dev_data_rd = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.dev_start) begin
        n_tests++;
        if (op_q.size() == 0) begin
          n_fail++;
          $display("FAIL dev_start: got unexpected start at addr %h, required none", bus.dev_addr);
        end else begin
          dev_op = op_q.pop_front();
          chk("dev_addr", 32'(bus.dev_addr), 32'(dev_op.addr));
          chk("dev_write", 32'(bus.dev_write), 32'(dev_op.wr));
          chk("dev_be", 32'(bus.dev_be), 32'(dev_op.be));
          if (dev_op.wr) chk("dev_data_wr", bus.dev_data_wr, dev_op.wdata);
          if (dev_op.lat > 0) begin
            repeat (dev_op.lat) @(posedge clk);
            #1;
            bus.dev_data_rd = dev_rd(dev_op.addr);
            if (dev_op.wr) begin
              for (int i = 0; i < 4; i++)
                if (dev_op.be[i]) dev_mem[dev_op.addr][i*8 +: 8] = dev_op.wdata[i*8 +: 8];
            end
            bus.dev_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.dev_ready = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every completion pops one expectation
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_starts = 0;
      end else begin
        if (bus.dev_start) mon_starts++;
        if (!bus.avl_waitrequest) begin
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL completion: got unexpected waitrequest low, required none");
          end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.is_read) chk("readdata", bus.avl_readdata, mon_e.rdata);
            chk("latency", 32'(cyc - mon_e.req_cyc), 32'(mon_e.cycles));
            chk("dev_starts", 32'(mon_starts), 32'(mon_e.starts));
          end
          mon_starts = 0;
        end
      end
    end
  end

  // Issue one transfer; l1/l2 are device latencies of first/second op, l1=0 means never ready
  task automatic do_xfer(input bit wr, input bit both, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input int l1, input int l2);
    exp_t e;
    logic [29:0] w;
    logic [31:0] old, merged;
    bit done;
    w = addr[31:2];
    old = ref_rd(w);
    merged = old;
    for (int i = 0; i < 4; i++) if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    @(negedge clk);
    e.req_cyc = cyc;
    e.is_read = !wr;
    e.rdata = (l1 == 0) ? 32'hFFFF_FFFF : old;
    if (!wr) begin
      e.cycles = (l1 == 0) ? TO + 2 : l1 + 2;
      e.starts = 1;
      op_q.push_back('{1'b0, w, 4'hF, 32'h0, l1});
    end else if (be == 4'h0) begin
      e.cycles = 1;
      e.starts = 0;
    end else if (be == 4'hF) begin
      e.cycles = l1 + 2;
      e.starts = 1;
      op_q.push_back('{1'b1, w, 4'hF, wdata, l1});
      ref_mem[w] = merged;
    end else begin
`ifdef BUS_SLAVE_RMW_EN
      e.cycles = l1 + l2 + 4;
      e.starts = 2;
      op_q.push_back('{1'b0, w, 4'hF, 32'h0, l1});
      op_q.push_back('{1'b1, w, 4'hF, merged, l2});
`else
      e.cycles = l1 + 2;
      e.starts = 1;
      op_q.push_back('{1'b1, w, be, wdata, l1});
`endif
      ref_mem[w] = merged;
    end
    sb_q.push_back(e);
    bus.avl_address = addr;
    bus.avl_write = wr;
    bus.avl_read = !wr || both;
    bus.avl_writedata = wdata;
    bus.avl_byteenable = be;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!bus.avl_waitrequest) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL xfer_timeout: got no completion in 100 cycles at addr %h, required completion", addr);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
    @(posedge clk);
    #1;
    bus.avl_read = 1'b0;
    bus.avl_write = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [31:0] a;
    bus.avl_address = 32'h0;
    bus.avl_read = 1'b0;
    bus.avl_write = 1'b0;
    bus.avl_writedata = 32'h0;
    bus.avl_byteenable = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_waitrequest", 32'(bus.avl_waitrequest), 32'h1);
    chk("rst_dev_start", 32'(bus.dev_start), 32'h0);
    chk("rst_dev_write", 32'(bus.dev_write), 32'h0);
    chk("rst_readdata", bus.avl_readdata, 32'h0);
    chk("rst_dev_addr", 32'(bus.dev_addr), 32'h0);
    chk("rst_dev_data_wr", bus.dev_data_wr, 32'h0);
    chk("rst_dev_be", 32'(bus.dev_be), 32'h0);
    rst_n = 1'b1;

    preload(30'h4, 32'hCAFE_BABE);
    do_xfer(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 3, 0);
    do_xfer(1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF, 2, 0);
    chk("full_write_mem", dev_rd(30'h8), 32'h1234_5678);

    preload(30'h10, 32'hAABB_CCDD);
    do_xfer(1'b1, 1'b0, 32'h0000_0040, 32'h1122_3344, 4'b0101, 2, 3);
    chk("partial_write_mem", dev_rd(30'h10), 32'hAA22_CC44);
    do_xfer(1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1, 0);

    do_xfer(1'b0, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 0, 0);

    preload(30'h30, 32'h5555_5555);
    do_xfer(1'b1, 1'b1, 32'h0000_00C0, 32'h0, 4'h0, 1, 0);
    chk("be0_mem", dev_rd(30'h30), 32'h5555_5555);

    op_q.push_back('{1'b0, 30'h5, 4'hF, 32'h0, 5});
    @(negedge clk);
    bus.avl_address = 32'h0000_0014;
    bus.avl_read = 1'b1;
    repeat (3) @(negedge clk);
    bus.avl_read = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midop_rst_waitrequest", 32'(bus.avl_waitrequest), 32'h1);
    chk("midop_rst_dev_start", 32'(bus.dev_start), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!bus.avl_waitrequest || bus.dev_start) ok = 1'b0;
    end
    chk("stale_ready_ignored", 32'(ok), 32'h1);

    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
              4'($urandom_range(0, 15)), $urandom_range(1, 6), $urandom_range(1, 6));
    end

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    chk("ops_drained", 32'(op_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
